// File: rtl/window_pkg.sv
// Shared types and defaults for the sliding-window sequencer.
package window_pkg;
    localparam int DW_DEF      = 12;
    localparam int WIN_LEN_DEF = 8;

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, CLR} state_t;

    // v: result is from a fully primed window; l: result closes the frame
    typedef struct packed {
        logic v;
        logic l;
    } tag_t;
endpackage

// File: rtl/window_tagpipe.sv
// LAT-deep tag delay line that tracks the datapath latency, with an empty flag.
module window_tagpipe
    import window_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic empty
);
    tag_t [LAT-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[LAT-1];
    assign empty   = (stage == '0);
endmodule

// File: rtl/window_seq.sv
// Frame sequencer for the sliding-window datapath: handshake, priming count,
// shift/clear strobes and primed-result tagging.
module window_seq
    import window_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int LAT     = 1,
    parameter int FCW     = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic           in_last,
    output logic           win_en,
    output logic           win_clr,
    output logic [DW-1:0]  win_data,
    input  logic [DW-1:0]  win_out,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    output logic           short_frame,
    output logic [FCW-1:0] frame_cnt
);
    localparam int CW = $clog2(WIN_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] CNT_PRE = CW'(WIN_LEN - 2);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [FCW-1:0] frames;
    logic           short_q;
    logic           ready_st, accept, primed, pipe_empty;
    tag_t           tag_in, tag_out;

    assign ready_st = (state == IDLE) || (state == FILL) || (state == RUN);
    assign in_ready = ~reset & ready_st;
    assign accept   = in_valid & in_ready;
    // cnt holds the number of earlier samples already in the window, so this
    // accept completes the window exactly when WIN_LEN-1 are already there
    assign primed   = (cnt == CNT_MAX);

    assign tag_in.v = accept & primed;
    assign tag_in.l = accept & in_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    if (in_last)             state_nxt = DRAIN;
                    else if (cnt == CNT_PRE) state_nxt = RUN;
                    else                     state_nxt = FILL;
                end
            end
            RUN:     if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = CLR;
            CLR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            frames  <= '0;
            short_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            short_q <= accept & in_last & ~primed;
            if (state == CLR) begin
                cnt    <= '0;
                frames <= frames + FCW'(1);
            end else if (accept && !primed) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    window_tagpipe #(.LAT(LAT)) u_tagpipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .empty   (pipe_empty)
    );

    // Everything is forced low while reset is asserted, registers included.
    assign win_en      = accept;
    assign win_data    = reset ? '0 : in_data;
    assign win_clr     = ~reset & (state == CLR);
    assign out_valid   = ~reset & tag_out.v;
    assign out_last    = out_valid & tag_out.l;
    assign out_data    = out_valid ? win_out : '0;
    assign short_frame = ~reset & short_q;
    assign frame_cnt   = reset ? '0 : frames;
endmodule

// File: tb/tb_window_seq.sv
// Bench for window_seq: 8-tap moving-sum datapath, frame-level model, directed frames.
module tb_window_seq;
    localparam int DW = 12, WIN_LEN = 8, LAT = 1, FCW = 2;

    logic           clk = 1'b0, reset = 1'b1;
    logic           in_valid = 1'b0, in_last = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready, win_en, win_clr, out_valid, out_last, short_frame;
    logic [DW-1:0]  win_data, win_out, out_data;
    logic [FCW-1:0] frame_cnt;

    always #5 clk = ~clk;

    window_seq #(.DW(DW), .WIN_LEN(WIN_LEN), .LAT(LAT), .FCW(FCW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .win_en(win_en), .win_clr(win_clr),
        .win_data(win_data), .win_out(win_out), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .short_frame(short_frame),
        .frame_cnt(frame_cnt)
    );

    // Datapath stand-in: sum of the last WIN_LEN shifted samples, LAT = 1.
    logic [DW-1:0] taps [WIN_LEN];
    always @(posedge clk) begin
        if (reset || win_clr) begin
            for (int i = 0; i < WIN_LEN; i++) taps[i] <= '0;
        end else if (win_en) begin
            taps[0] <= win_data;
            for (int i = 1; i < WIN_LEN; i++) taps[i] <= taps[i-1];
        end
    end
    always_comb begin
        win_out = '0;
        for (int i = 0; i < WIN_LEN; i++) win_out = win_out + taps[i];
    end

    // Frame model: samples of the current frame; a sample yields a result
    // when at least WIN_LEN samples of the frame have been seen.
    int            hist[$];
    logic          exp_v = 1'b0, exp_l = 1'b0, exp_short = 1'b0;
    logic [DW-1:0] exp_d = '0;

    function automatic int window_sum();
        int s;
        s = 0;
        for (int i = hist.size() - WIN_LEN; i < hist.size(); i++) s += hist[i];
        return s;
    endfunction

    always @(posedge clk) begin
        exp_v <= 1'b0; exp_l <= 1'b0; exp_short <= 1'b0; exp_d <= '0;
        if (reset) begin
            hist.delete();
        end else if (in_valid && in_ready) begin
            hist.push_back(int'(in_data));
            if (hist.size() >= WIN_LEN) begin
                exp_v <= 1'b1;
                exp_l <= in_last;
                exp_d <= DW'(window_sum());
            end else if (in_last) begin
                exp_short <= 1'b1;
            end
            if (in_last) hist.delete();
        end
    end

    // Running event tallies used by the per-frame checks.
    int            en_tot = 0, clr_tot = 0, last_tot = 0, short_tot = 0;
    logic [DW-1:0] outs[$];
    always @(negedge clk) begin
        if (!reset) begin
            en_tot    <= en_tot + int'(win_en);
            clr_tot   <= clr_tot + int'(win_clr);
            last_tot  <= last_tot + int'(out_last);
            short_tot <= short_tot + int'(short_frame);
            if (out_valid) outs.push_back(out_data);
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic cycle_check();
        if (reset) begin
            chk("reset_outputs_zero",
                int'(in_ready | win_en | win_clr | out_valid | out_last | short_frame |
                     (|frame_cnt) | (|win_data) | (|out_data)), 0);
        end else begin
            chk("out_valid", int'(out_valid), int'(exp_v));
            chk("out_data", int'(out_data), exp_v ? int'(exp_d) : 0);
            chk("out_last", int'(out_last), int'(exp_v & exp_l));
            chk("short_frame", int'(short_frame), int'(exp_short));
            chk("win_data", int'(win_data), int'(in_data));
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input bit first, input bit gaps);
        bit acc;
        int w;
        if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_last = last; w = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            if (!first) chk("in_ready_mid_frame", int'(in_ready), 1);
            @(posedge clk); #1;
            if (acc) break;
            w++;
            if (w > LAT + 3) begin chk("accept_timeout", w, LAT + 3); break; end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 10) begin chk("idle_timeout", w, 10); break; end
        end
        chk("gap_at_least_lat_plus_1", int'(w >= LAT + 1), 1);
        @(posedge clk); #1;
    endtask

    task automatic frame(input string tag, input int n, input int base, input bit gaps,
                         input int exp_outs, input int exp_first, input int exp_lastd,
                         input int exp_short, input int exp_fc);
        int en0, clr0, last0, short0, o0;
        en0 = en_tot; clr0 = clr_tot; last0 = last_tot; short0 = short_tot; o0 = outs.size();
        for (int i = 0; i < n; i++) send(DW'(base + i), i == n - 1, i == 0, gaps);
        wait_idle();
        chk({tag, "_win_en_count"}, en_tot - en0, n);
        chk({tag, "_win_clr_count"}, clr_tot - clr0, 1);
        chk({tag, "_out_count"}, outs.size() - o0, exp_outs);
        chk({tag, "_out_last_count"}, last_tot - last0, exp_outs > 0 ? 1 : 0);
        chk({tag, "_short_count"}, short_tot - short0, exp_short);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), exp_fc);
        if (outs.size() - o0 > 0) begin
            chk({tag, "_first_out"}, int'(outs[o0]), exp_first);
            chk({tag, "_final_out"}, int'(outs[outs.size() - 1]), exp_lastd);
        end
    endtask

    int fc_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        fork
            forever begin @(negedge clk); cycle_check(); end
        join_none
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the middle of a running frame.
        for (int i = 0; i < 10; i++) send(DW'(i + 1), 1'b0, i == 0, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = DW'(5);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", int'(in_ready), 1);
        chk("post_reset_frame_cnt", int'(frame_cnt), 0);
        chk("post_reset_no_out_last", last_tot, 0);
        chk("post_reset_no_clr", clr_tot, 0);
        @(posedge clk); #1;

        // 1..20: outputs for samples 8..20, first sum(1..8)=36, last sum(13..20)=132
        frame("cont20", 20, 1, 1'b0, 13, 36, 132, 0, 1);
        // 5-sample short frame
        frame("short5", 5, 1, 1'b0, 0, 0, 0, 1, 2);
        // exactly 8 samples 10..17: a single output of 108 carrying out_last
        frame("exact8", 8, 10, 1'b0, 1, 108, 108, 0, 3);
        // 30 samples with idle gaps: first 36, last sum(23..30)=212; frame_cnt wraps
        frame("gaps30", 30, 1, 1'b1, 23, 36, 212, 0, 0);
        // five short frames
        for (int k = 0; k < 5; k++) frame("wrap", 3, 50, 1'b0, 0, 0, 0, 1, fc_seq[k]);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
